// File: rtl/rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_framer
//  Purpose  : HDLC receive framer: flag/abort detection, zero removal, bytes.
//  Revision : 1.0  initial release
// ============================================================================
module rx_framer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_EndOfFrame,
    output logic       Rx_FrameError
);

    localparam logic [7:0] c_FLAG     = 8'h7E;
    localparam logic [7:0] c_ABORT    = 8'hFE;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SYNC  = 2'd1;
    localparam logic [1:0] c_ST_FRAME = 2'd2;

    logic       r_rxd_q,    w_rxd_d;
    logic [7:0] r_shift_q,  w_shift_d;
    logic [2:0] r_supp_q,   w_supp_d;
    logic [2:0] r_ones_q,   w_ones_d;
    logic [2:0] r_bitcnt_q, w_bitcnt_d;
    logic [7:0] r_asm_q,    w_asm_d;
    logic [1:0] r_state_q,  w_state_d;
    logic [7:0] r_data_q,   w_data_d;
    logic       r_flag_q,   w_flag_d;
    logic       r_abort_q,  w_abort_d;
    logic       r_valid_q,  w_valid_d;
    logic       r_newbyte_q, w_newbyte_d;
    logic       r_eof_q,    w_eof_d;
    logic       r_ferr_q,   w_ferr_d;

    logic w_flag_hit, w_abort_hit, w_exit, w_active, w_suppressed, w_stuffed, w_kept;

    assign w_flag_hit   = (r_shift_q == c_FLAG);
    assign w_abort_hit  = (r_shift_q == c_ABORT);
    assign w_exit       = r_shift_q[0];
    assign w_active     = (r_state_q != c_ST_IDLE);
    assign w_suppressed = (r_supp_q != 3'd0);
    assign w_stuffed    = !w_exit && (r_ones_q == 3'd5);
    // The exiting bit that coincides with a detect is itself the first flag/abort bit.
    assign w_kept       = w_active && !w_suppressed && !w_stuffed && !w_flag_hit && !w_abort_hit;

    always_comb begin
        w_rxd_d     = Rx;
        w_shift_d   = {r_rxd_q, r_shift_q[7:1]};
        w_supp_d    = r_supp_q;
        w_ones_d    = r_ones_q;
        w_bitcnt_d  = r_bitcnt_q;
        w_asm_d     = r_asm_q;
        w_state_d   = r_state_q;
        w_data_d    = r_data_q;
        w_flag_d    = 1'b0;
        w_abort_d   = 1'b0;
        w_valid_d   = (r_state_q == c_ST_FRAME);
        w_newbyte_d = 1'b0;
        w_eof_d     = 1'b0;
        w_ferr_d    = 1'b0;

        if (w_suppressed) begin
            w_supp_d = r_supp_q - 3'd1;
        end else if (w_active) begin
            if (w_exit) begin
                w_ones_d = (r_ones_q == 3'd7) ? 3'd7 : r_ones_q + 3'd1;
            end else begin
                w_ones_d = 3'd0;
            end
        end

        if (w_kept) begin
            w_asm_d    = {w_exit, r_asm_q[7:1]};
            w_bitcnt_d = r_bitcnt_q + 3'd1;
            if (r_bitcnt_q == 3'd7) begin
                w_data_d    = {w_exit, r_asm_q[7:1]};
                w_newbyte_d = 1'b1;
            end
            if (r_state_q == c_ST_SYNC) begin
                w_state_d = c_ST_FRAME;
            end
        end

        if (w_abort_hit) begin
            w_abort_d  = 1'b1;
            w_state_d  = c_ST_IDLE;
            w_bitcnt_d = 3'd0;
            w_ones_d   = 3'd0;
            w_supp_d   = 3'd0;
        end else if (w_flag_hit) begin
            w_flag_d   = 1'b1;
            w_state_d  = c_ST_SYNC;
            w_bitcnt_d = 3'd0;
            w_ones_d   = 3'd0;
            w_supp_d   = 3'd7;
            if (r_state_q == c_ST_FRAME) begin
                w_eof_d  = 1'b1;
                w_ferr_d = (r_bitcnt_q != 3'd0);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_rxd_q     <= 1'b1;
            r_shift_q   <= 8'hFF;
            r_supp_q    <= 3'd0;
            r_ones_q    <= 3'd0;
            r_bitcnt_q  <= 3'd0;
            r_asm_q     <= 8'h00;
            r_state_q   <= c_ST_IDLE;
            r_data_q    <= 8'h00;
            r_flag_q    <= 1'b0;
            r_abort_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            r_newbyte_q <= 1'b0;
            r_eof_q     <= 1'b0;
            r_ferr_q    <= 1'b0;
        end else begin
            r_rxd_q     <= w_rxd_d;
            r_shift_q   <= w_shift_d;
            r_supp_q    <= w_supp_d;
            r_ones_q    <= w_ones_d;
            r_bitcnt_q  <= w_bitcnt_d;
            r_asm_q     <= w_asm_d;
            r_state_q   <= w_state_d;
            r_data_q    <= w_data_d;
            r_flag_q    <= w_flag_d;
            r_abort_q   <= w_abort_d;
            r_valid_q   <= w_valid_d;
            r_newbyte_q <= w_newbyte_d;
            r_eof_q     <= w_eof_d;
            r_ferr_q    <= w_ferr_d;
        end
    end

    assign Rx_FlagDetect  = r_flag_q;
    assign Rx_AbortDetect = r_abort_q;
    assign Rx_ValidFrame  = r_valid_q;
    assign Rx_Data        = r_data_q;
    assign Rx_NewByte     = r_newbyte_q;
    assign Rx_EndOfFrame  = r_eof_q;
    assign Rx_FrameError  = r_ferr_q;

endmodule
`default_nettype wire
